mdu_seq: RTL and testbench

- Multi-cycle multiply/divide unit (MDU) sequencer for the MIPS integer datapath.
- Accepts MULT/MULTU/DIV/DIVU commands with 32-bit operands S and T.
- Runs an iterative shift-add multiply or a restoring divide, then writes the 64-bit result into the HI/LO result registers.
- Drives busy to the pipeline hazard unit, which stalls MFHI/MFLO and new MDU ops while busy is high.

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_sign_fix.sv | 18 +
 rtl/mdu_seq.sv | 192 +++++++++++++++++++
 tb/tb_mdu_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: op encodings,
// sequencer states and the default operand width.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    FIX  = 3'd2,
    ZDIV = 3'd3,
    DONE = 3'd4
  } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate, used both for operand magnitudes and
// for sign correction of the final product, quotient and remainder.
module mdu_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val
);

  always_comb begin
    o_val = i_val;
    if (i_neg) begin
      o_val = (~i_val) + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// MIPS MDU sequencer: iterative shift-add multiply and restoring divide
// writing HI/LO. Build option MDU_EARLY_OUT_EN ends a multiply once the
// remaining multiplier is zero.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] T,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] Y_hi,
  output logic [WIDTH-1:0] Y_lo
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  mdu_state_e r_state, w_state_next;

  logic               r_is_div;
  logic               r_s_sign;
  logic               r_t_sign;
  logic [CntW-1:0]    r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  // Multiplier during MULT; dividend shifting out / quotient shifting in during DIV.
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_y_hi;
  logic [WIDTH-1:0]   r_y_lo;
  logic               r_dbz;

  logic               w_op_signed;
  logic               w_op_div;
  logic               w_t_zero;
  logic               w_s_neg;
  logic               w_t_neg;
  logic [WIDTH-1:0]   w_s_mag;
  logic [WIDTH-1:0]   w_t_mag;
  logic [2*WIDTH-1:0] w_acc_add;
  logic [WIDTH-1:0]   w_mplier_shift;
  logic [WIDTH:0]     w_rem_shift;
  logic [WIDTH:0]     w_div_ext;
  logic               w_rem_ge;
  logic [WIDTH-1:0]   w_rem_sub;
  logic [WIDTH-1:0]   w_dvd_shift;
  logic               w_early;
  logic               w_run_last;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_op_div    = op[1];
  assign w_t_zero    = (T == '0);
  assign w_s_neg     = w_op_signed & S[WIDTH-1];
  assign w_t_neg     = w_op_signed & T[WIDTH-1];

  mdu_sign_fix #(.WIDTH(WIDTH)) u_mag_s (.i_neg(w_s_neg), .i_val(S), .o_val(w_s_mag));
  mdu_sign_fix #(.WIDTH(WIDTH)) u_mag_t (.i_neg(w_t_neg), .i_val(T), .o_val(w_t_mag));

  assign w_acc_add      = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplier_shift = r_mplier >> 1;

  // Restoring divide step: the extra top bit keeps the shifted-out carry for the compare.
  assign w_rem_shift = {r_rem, r_mplier[WIDTH-1]};
  assign w_div_ext   = {1'b0, r_mcand[WIDTH-1:0]};
  assign w_rem_ge    = (w_rem_shift >= w_div_ext);
  assign w_rem_sub   = w_rem_ge ? WIDTH'(w_rem_shift - w_div_ext) : w_rem_shift[WIDTH-1:0];
  assign w_dvd_shift = {r_mplier[WIDTH-2:0], w_rem_ge};

`ifdef MDU_EARLY_OUT_EN
  assign w_early = ~r_is_div & (w_mplier_shift == '0);
`else
  assign w_early = 1'b0;
`endif

  assign w_run_last = (r_cnt == CntLast) | w_early;

  mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .i_neg(r_s_sign ^ r_t_sign),
    .i_val(r_acc),
    .o_val(w_prod_fix)
  );
  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
    .i_neg(r_s_sign ^ r_t_sign),
    .i_val(r_mplier),
    .o_val(w_quo_fix)
  );
  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .i_neg(r_s_sign),
    .i_val(r_rem),
    .o_val(w_rem_fix)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = (w_op_div && w_t_zero) ? ZDIV : RUN;
        end
      end
      RUN:     if (w_run_last) w_state_next = FIX;
      FIX:     w_state_next = DONE;
      ZDIV:    w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_div <= 1'b0;
      r_s_sign <= 1'b0;
      r_t_sign <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_y_hi   <= '0;
      r_y_lo   <= '0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_is_div <= w_op_div;
            r_s_sign <= w_s_neg;
            r_t_sign <= w_t_neg;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            if (w_op_div) begin
              // Divide by zero keeps raw S so HI can return it unmodified.
              r_mplier <= w_t_zero ? S : w_s_mag;
              r_mcand  <= {{WIDTH{1'b0}}, w_t_mag};
            end else begin
              r_mplier <= w_t_mag;
              r_mcand  <= {{WIDTH{1'b0}}, w_s_mag};
            end
          end
        end
        RUN: begin
          r_cnt <= r_cnt + CntW'(1);
          if (r_is_div) begin
            r_rem    <= w_rem_sub;
            r_mplier <= w_dvd_shift;
          end else begin
            r_acc    <= w_acc_add;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_shift;
          end
        end
        FIX: begin
          r_y_hi <= r_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
          r_y_lo <= r_is_div ? w_quo_fix : w_prod_fix[WIDTH-1:0];
        end
        ZDIV: begin
          r_y_hi <= r_mplier;
          r_y_lo <= '1;
          r_dbz  <= 1'b1;
        end
        DONE:    r_dbz <= 1'b0;
        default: r_dbz <= 1'b0;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign div_by_zero = r_dbz;
  assign Y_hi        = r_y_hi;
  assign Y_lo        = r_y_lo;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq; latency expectations follow the
// MDU_EARLY_OUT_EN build setting.
module tb_mdu_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] S;
  logic [31:0] T;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] Y_hi;
  logic [31:0] Y_lo;

  int errors = 0;
  int checks = 0;

`ifdef MDU_EARLY_OUT_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  mdu_seq dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .S(S),
    .T(T),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .Y_hi(Y_hi),
    .Y_lo(Y_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, optionally poke a second start while busy, then check
  // latency, busy coverage, results and the return to idle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] s,
                        input logic [31:0] t, input int lat, input logic [31:0] hi,
                        input logic [31:0] lo, input logic dbz, input int poke_at);
    int n;
    int busy_low;
    start = 1'b1;
    op    = o;
    S     = s;
    T     = t;
    step();
    start    = 1'b0;
    n        = 1;
    busy_low = 0;
    while (!done && n < 100) begin
      if (n == poke_at) begin
        start = 1'b1;
        op    = 2'b01;
        S     = 32'd2;
        T     = 32'd3;
      end
      if (n == poke_at + 1) start = 1'b0;
      if (!busy) busy_low++;
      step();
      n++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_busy_low_cycles"}, 64'(busy_low), 64'd0);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd1);
    chk({tag, "_hi"}, 64'(Y_hi), 64'(hi));
    chk({tag, "_lo"}, 64'(Y_lo), 64'(lo));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(dbz));
    step();
    chk({tag, "_idle_after"}, {62'd0, busy, done}, 64'd0);
    chk({tag, "_dbz_cleared"}, 64'(div_by_zero), 64'd0);
    step();
    chk({tag, "_not_queued"}, 64'(busy), 64'd0);
    chk({tag, "_hold"}, {Y_hi, Y_lo}, {hi, lo});
  endtask

  initial begin
    int dones;
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    S     = '0;
    T     = '0;
    #1;
    chk("reset_outputs", {29'd0, busy, done, div_by_zero, Y_hi}, 64'd0);
    chk("reset_lo", 64'(Y_lo), 64'd0);
    step();
    step();
    reset = 1'b0;
    step();

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34,
           32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, Early ? 5 : 34,
           32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 34,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    run_op("divu_poke", 2'b11, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0, 5);
    run_op("divu_zero", 2'b11, 32'd5, 32'd0, 2, 32'd5, 32'hFFFF_FFFF, 1'b1, 1);
    run_op("div_zero_neg", 2'b10, 32'hFFFF_FFFB, 32'd0, 2,
           32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 34,
           32'h0000_0000, 32'h8000_0000, 1'b0, 0);
    run_op("multu_early", 2'b01, 32'h1234, 32'd3, Early ? 4 : 34,
           32'd0, 32'h369C, 1'b0, 0);
    run_op("multu_zero", 2'b01, 32'hDEAD, 32'd0, Early ? 3 : 34, 32'd0, 32'd0, 1'b0, 0);
    run_op("mult_pos", 2'b00, 32'd6, 32'd7, Early ? 5 : 34, 32'd0, 32'd42, 1'b0, 0);

    // Leave a non-zero result in HI/LO, then abort a multiply with reset.
    run_op("multu_pre", 2'b01, 32'h0001_0000, 32'h0001_0001, Early ? 19 : 34,
           32'h0000_0001, 32'h0001_0000, 1'b0, 0);
    start = 1'b1;
    op    = 2'b01;
    S     = 32'd7;
    T     = 32'd9;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_y", {Y_hi, Y_lo}, 64'd0);
    step();
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      step();
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    chk("abort_idle", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
